// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode constants, the format
// code enumeration, the decoded entry struct, FSM state constants and a
// small funct7 legality helper.
// The struct carries the immediate and PC at their maximum widths (64 bits).
// Each instance narrows them to XLEN / PC_W at its outputs.
package decode_pkg;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP32     = 7'b0111011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM32    = 7'b0011011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Occupancy states of the skid-buffered pipe.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [63:0] imm;
        fmt_t        fmt;
        logic        illegal;
        logic [63:0] pc;
    } decoded_t;

    localparam decoded_t DECODED_RESET = '{
        opcode:  7'd0,
        rd:      5'd0,
        rs1:     5'd0,
        rs2:     5'd0,
        funct3:  3'd0,
        funct7:  7'd0,
        imm:     64'd0,
        fmt:     FMT_NONE,
        illegal: 1'b0,
        pc:      64'd0
    };

    function automatic logic r_funct7_ok(input logic [6:0] f7);
        return (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
    endfunction

endpackage

// File: rtl/decode_stage_instr_field_decode.sv
// instr_field_decode: purely combinational split of one 32-bit instruction.
// Ports:
//   instr : raw instruction word
//   dec   : decoded fields, 64-bit sign-extended immediate, format, illegal.
//           The pc member is left at zero; the caller fills it in.
// XLEN selects whether the OP-32 / OP-IMM-32 opcodes are recognised.
module instr_field_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0] op;
    logic       sgn;

    assign op  = instr[6:0];
    assign sgn = instr[31];

    always_comb begin
        dec        = DECODED_RESET;
        dec.opcode = op;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];

        case (op)
            OP_OP:                                    dec.fmt = FMT_R;
            OP_OP32:                                  dec.fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM,
            OP_MISC_MEM:                              dec.fmt = FMT_I;
            OP_IMM32:                                 dec.fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            OP_STORE:                                 dec.fmt = FMT_S;
            OP_BRANCH:                                dec.fmt = FMT_B;
            OP_LUI, OP_AUIPC:                         dec.fmt = FMT_U;
            OP_JAL:                                   dec.fmt = FMT_J;
            default:                                  dec.fmt = FMT_NONE;
        endcase

        // Sign bit is always instr[31]; every immediate is built at 64 bits
        // so narrowing to XLEN later keeps the sign extension intact.
        case (dec.fmt)
            FMT_I:   dec.imm = {{52{sgn}}, instr[31:20]};
            FMT_S:   dec.imm = {{52{sgn}}, instr[31:25], instr[11:7]};
            FMT_B:   dec.imm = {{51{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   dec.imm = {{32{sgn}}, instr[31:12], 12'd0};
            FMT_J:   dec.imm = {{43{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: dec.imm = 64'd0;
        endcase

        dec.illegal = (op[1:0] != 2'b11)
                   || (dec.fmt == FMT_NONE)
                   || ((dec.fmt == FMT_R) && !r_funct7_ok(instr[31:25]));
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode between fetch and execute.
// Ports:
//   clk, rst_n (async, active-low), flush (sync discard of held entries)
//   in_valid/in_ready/in_instr/in_pc     : upstream instruction stream
//   out_valid/out_ready                  : downstream handshake
//   out_opcode..out_funct7, out_imm, out_fmt, out_illegal, out_pc : entry
//   dbg_state                            : occupancy (EMPTY/ONE/TWO)
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; a producer holding valid keeps its payload stable until it transfers,
// and out_* stays stable while out_valid && !out_ready.
// SKID=1: two entries (main + skid) with a registered in_ready.
// SKID=0: one entry with in_ready = !out_valid || out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      dbg_state
);

    decoded_t dec;
    decoded_t d_in;
    decoded_t main_q;
    logic     accept;
    logic     present;

    instr_field_decode #(.XLEN(XLEN)) u_field_decode (
        .instr (in_instr),
        .dec   (dec)
    );

    always_comb begin
        d_in    = dec;
        d_in.pc = 64'(in_pc);
    end

    assign accept  = in_valid && in_ready;
    assign present = out_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            logic [1:0] state_q;
            logic       rdy_q;
            decoded_t   skid_q;

            // rdy_q always equals (state_q != ST_TWO); kept as its own flop so
            // fetch sees in_ready straight from a register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_EMPTY;
                    rdy_q   <= 1'b1;
                    main_q  <= DECODED_RESET;
                    skid_q  <= DECODED_RESET;
                end else if (flush) begin
                    state_q <= ST_EMPTY;
                    rdy_q   <= 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (accept) begin
                                main_q  <= d_in;
                                state_q <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (accept && !present) begin
                                skid_q  <= d_in;
                                state_q <= ST_TWO;
                                rdy_q   <= 1'b0;
                            end else if (accept && present) begin
                                main_q  <= d_in;
                            end else if (present) begin
                                state_q <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            // No accept possible here: in_ready is low.
                            if (present) begin
                                main_q  <= skid_q;
                                state_q <= ST_ONE;
                                rdy_q   <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_EMPTY;
                            rdy_q   <= 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready  = rdy_q;
            assign out_valid = (state_q != ST_EMPTY);
            assign dbg_state = state_q;
        end else begin : g_pipe
            logic valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    main_q  <= DECODED_RESET;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    main_q  <= d_in;
                end else if (present) begin
                    valid_q <= 1'b0;
                end
            end

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign dbg_state = valid_q ? ST_ONE : ST_EMPTY;
        end
    endgenerate

    assign out_opcode  = main_q.opcode;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_imm     = XLEN'(main_q.imm);
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_pc      = PC_W'(main_q.pc);

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        out_ready = 1'b0;

  // DUT A: XLEN=32, SKID=1
  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic [31:0] out_imm, out_pc;
  logic [1:0]  dbg_state;

  // DUT B: XLEN=64, SKID=0
  logic        in_ready64, out_valid64, out_illegal64;
  logic [6:0]  out_opcode64, out_funct764;
  logic [4:0]  out_rd64, out_rs164, out_rs264;
  logic [2:0]  out_funct364, out_fmt64;
  logic [63:0] out_imm64;
  logic [31:0] out_pc64;
  logic [1:0]  dbg_state64;

  decode_stage #(.XLEN(32), .PC_W(32), .SKID(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc), .dbg_state(dbg_state)
  );

  decode_stage #(.XLEN(64), .PC_W(32), .SKID(1'b0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_opcode(out_opcode64), .out_rd(out_rd64), .out_rs1(out_rs164), .out_rs2(out_rs264),
    .out_funct3(out_funct364), .out_funct7(out_funct764), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_pc(out_pc64), .dbg_state(dbg_state64)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] pc;
  } exp_t;
  localparam int EW = $bits(exp_t);

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit rv64);
    exp_t e;
    int s;
    int unsigned u;
    longint v;
    logic [6:0] op;
    s = $signed(ins);
    u = ins;
    op = ins[6:0];
    e.opcode = op;
    e.rd = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.f3 = ins[14:12];
    e.f7 = ins[31:25];
    if (op == 7'h33 || (rv64 && op == 7'h3B)) e.fmt = 3'd0;
    else if ((op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F}) || (rv64 && op == 7'h1B)) e.fmt = 3'd1;
    else if (op == 7'h23) e.fmt = 3'd2;
    else if (op == 7'h63) e.fmt = 3'd3;
    else if (op inside {7'h37, 7'h17}) e.fmt = 3'd4;
    else if (op == 7'h6F) e.fmt = 3'd5;
    else e.fmt = 3'd7;
    case (e.fmt)
      3'd1: v = longint'(s >>> 20);
      3'd2: v = longint'(s >>> 25) * 32 + longint'((u >> 7) % 32);
      3'd3: v = longint'(s >>> 31) * 4096 + longint'((u >> 7) % 2) * 2048
              + longint'((u >> 25) % 64) * 32 + longint'((u >> 8) % 16) * 2;
      3'd4: v = longint'(s >>> 12) * 4096;
      3'd5: v = longint'(s >>> 31) * 1048576 + longint'((u >> 12) % 256) * 4096
              + longint'((u >> 20) % 2) * 2048 + longint'((u >> 21) % 1024) * 2;
      default: v = 0;
    endcase
    e.imm = rv64 ? 64'(v) : {32'd0, v[31:0]};
    e.ill = (ins[1:0] != 2'b11) || (e.fmt == 3'd7)
         || (e.fmt == 3'd0 && !(e.f7 inside {7'h00, 7'h20, 7'h01}));
    e.pc = pc;
    return e;
  endfunction

  function automatic exp_t obs32();
    exp_t o;
    o = '{opcode: out_opcode, rd: out_rd, rs1: out_rs1, rs2: out_rs2, f3: out_funct3,
          f7: out_funct7, imm: {32'd0, out_imm}, fmt: out_fmt, ill: out_illegal, pc: out_pc};
    return o;
  endfunction

  function automatic exp_t obs64();
    exp_t o;
    o = '{opcode: out_opcode64, rd: out_rd64, rs1: out_rs164, rs2: out_rs264, f3: out_funct364,
          f7: out_funct764, imm: out_imm64, fmt: out_fmt64, ill: out_illegal64, pc: out_pc64};
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_q64[$];
  exp_t prev32, prev64;
  bit stall32 = 1'b0;
  bit stall64 = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    exp_t o, e;
    if (!rst_n) begin
      exp_q.delete();
      exp_q64.delete();
      stall32 = 1'b0;
      stall64 = 1'b0;
    end else begin
      // DUT A
      o = obs32();
      check("valid32_vs_occupancy", 160'(out_valid), 160'(exp_q.size() != 0));
      check("ready32_vs_occupancy", 160'(in_ready), 160'(exp_q.size() < 2));
      if (stall32) check("hold32", 160'({out_valid, o}), 160'({1'b1, prev32}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL present32: got pc %0h expected no entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("data32", 160'(o), 160'(e));
        end
      end
      stall32 = out_valid && !out_ready && !flush;
      prev32 = o;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(ref_decode(in_instr, in_pc, 1'b0));

      // DUT B
      o = obs64();
      check("valid64_vs_occupancy", 160'(out_valid64), 160'(exp_q64.size() != 0));
      check("ready64_rule", 160'(in_ready64), 160'(exp_q64.size() == 0 || out_ready));
      if (stall64) check("hold64", 160'({out_valid64, o}), 160'({1'b1, prev64}));
      if (out_valid64 && out_ready) begin
        if (exp_q64.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL present64: got pc %0h expected no entry", out_pc64);
        end else begin
          e = exp_q64.pop_front();
          check("data64", 160'(o), 160'(e));
        end
      end
      stall64 = out_valid64 && !out_ready && !flush;
      prev64 = o;
      if (flush) exp_q64.delete();
      else if (in_valid && in_ready64) exp_q64.push_back(ref_decode(in_instr, in_pc, 1'b1));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 14))
      0: r[6:0] = 7'h33;   1: r[6:0] = 7'h3B;   2: r[6:0] = 7'h13;
      3: r[6:0] = 7'h03;   4: r[6:0] = 7'h67;   5: r[6:0] = 7'h73;
      6: r[6:0] = 7'h0F;   7: r[6:0] = 7'h1B;   8: r[6:0] = 7'h23;
      9: r[6:0] = 7'h63;  10: r[6:0] = 7'h37;  11: r[6:0] = 7'h17;
      12: r[6:0] = 7'h6F;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3, fmt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] got[$];
  bit acc, hold;

  initial begin
    vecs[0] = '{32'hFFF10093, 5'd1, 5'd2, 5'd31, 3'd0, 3'd1, 32'hFFFFFFFF, 1'b0}; // addi x1,x2,-1
    vecs[1] = '{32'h00532423, 5'd8, 5'd6, 5'd5,  3'd2, 3'd2, 32'h00000008, 1'b0}; // sw x5,8(x6)
    vecs[2] = '{32'h123451B7, 5'd3, 5'd8, 5'd3,  3'd5, 3'd4, 32'h12345000, 1'b0}; // lui x3,0x12345
    vecs[3] = '{32'h00000000, 5'd0, 5'd0, 5'd0,  3'd0, 3'd7, 32'h00000000, 1'b1}; // all zero
    vecs[4] = '{32'hFE3100B3, 5'd1, 5'd2, 5'd3,  3'd0, 3'd0, 32'h00000000, 1'b1}; // R funct7=7F
    vecs[5] = '{32'h003100B3, 5'd1, 5'd2, 5'd3,  3'd0, 3'd0, 32'h00000000, 1'b0}; // add
    vecs[6] = '{32'h00000463, 5'd8, 5'd0, 5'd0,  3'd0, 3'd3, 32'h00000008, 1'b0}; // beq +8
    vecs[7] = '{32'h0010006F, 5'd0, 5'd0, 5'd1,  3'd0, 3'd5, 32'h00000800, 1'b0}; // jal +0x800
    vecs[8] = '{32'h00000010, 5'd0, 5'd0, 5'd0,  3'd0, 3'd7, 32'h00000000, 1'b1}; // opcode[1:0]=00

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 160'(out_valid), 160'(0));
    check("reset_ready", 160'(in_ready), 160'(1));
    check("reset_fields", 160'({out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                                out_imm, out_illegal, out_pc}), 160'(0));
    check("reset_fmt", 160'(out_fmt), 160'(7));
    check("reset_valid64", 160'(out_valid64), 160'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // table: one vector per cycle, back-to-back, out_ready=1
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc = 32'h1000 + 32'(4 * i);
      step();
      check($sformatf("vec%0d", i),
            160'({out_valid, out_rd, out_rs1, out_rs2, out_funct3, out_fmt, out_imm, out_illegal, out_pc}),
            160'({1'b1, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].fmt,
                  vecs[i].imm, vecs[i].ill, 32'h1000 + 32'(4 * i)}));
    end
    in_valid = 1'b0;
    step();
    check("drained_after_table", 160'(out_valid), 160'(0));

    // three instructions against a stalled output
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h100;
    step();
    check("stall_one_ready", 160'(in_ready), 160'(1));
    in_instr = 32'h00200113; in_pc = 32'h104;
    step();
    check("stall_skid_full", 160'(in_ready), 160'(0));
    in_instr = 32'h00300193; in_pc = 32'h108;
    step();
    check("stall_hold", 160'({in_ready, out_valid, out_pc}), 160'({1'b0, 1'b1, 32'h100}));
    step();
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_pc);
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("stall_count", 160'(got.size()), 160'(3));
    for (int k = 0; k < 3; k++)
      check($sformatf("stall_order%0d", k), 160'(k < got.size() ? got[k] : 32'hDEAD),
            160'(32'h100 + 32'(4 * k)));
    step();

    // flush in TWO with an input offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h200;
    step();
    in_pc = 32'h204;
    step();
    check("flush_pre_two", 160'(in_ready), 160'(0));
    in_pc = 32'h208; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_empty", 160'({out_valid, in_ready}), 160'({1'b0, 1'b1}));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush_nothing_presented", 160'(out_valid), 160'(0));
    end

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h280;
    step();
    in_pc = 32'h284;
    step();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_ready", 160'({out_valid, in_ready, out_valid64}), 160'({1'b0, 1'b1, 1'b0}));
    check("async_rst_fields", 160'({out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                                    out_imm, out_illegal, out_pc, out_fmt}), 160'(3'd7));
    @(posedge clk);
    #2;
    in_valid = 1'b1; in_instr = 32'h123451B7; in_pc = 32'h300; out_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("first_accept_after_rst", 160'({out_valid, out_pc, out_fmt}), 160'({1'b1, 32'h300, 3'd4}));
    in_valid = 1'b0;
    step();

    // randomized traffic, both DUTs checked by the scoreboard
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hold = in_valid && !in_ready && !flush;
      step();
      flush = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr();
        in_pc = $urandom;
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    check("final_queue32_empty", 160'(exp_q.size()), 160'(0));
    check("final_queue64_empty", 160'(exp_q64.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I/RV64I decode stage sitting between fetch and register-read/execute. Splits each accepted instruction into its fields and classifies its format. Produces the sign-extended immediate and flags illegal encodings. Results are registered behind a valid/ready handshake, with an optional 2-entry skid buffer so fetch sees a registered `in_ready` at full throughput.

## Interface
- `XLEN`, 32: datapath width, 32 or 64. Sets immediate width. 64 enables the OP-32/OP-IMM-32 opcodes.
- `PC_W`, 32: PC width carried alongside the instruction.
- `SKID`, 1: 1 gives a 2-entry skid buffer with registered `in_ready`. 0 gives a single pipe register with combinational `in_ready`.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous discard of all held entries.
- `in_valid` input 1: upstream instruction valid.
- `in_ready` output 1: stage can accept.
- `in_instr` input 32: raw instruction word.
- `in_pc` input PC_W: PC of `in_instr`.
- `out_valid` output 1: decoded entry valid.
- `out_ready` input 1: downstream accepts.
- `out_opcode`, `out_rd`, `out_rs1`, `out_rs2`, `out_funct3`, `out_funct7` output 7/5/5/5/3/7: bit fields [6:0], [11:7], [19:15], [24:20], [14:12], [31:25].
- `out_imm` output XLEN: sign-extended immediate; 0 for R-type.
- `out_fmt` output 3: format code, R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- `out_illegal` output 1: encoding not supported.
- `out_pc` output PC_W: PC of the presented entry.

## Operation
- **Accept and present.**
  - An input is accepted when `in_valid && in_ready`. Present when `out_valid && out_ready`.
  - Decode is combinational on `in_instr`; the results are stored at accept.
- **Format by opcode.**
  - R: 0110011, plus 0111011 if XLEN=64.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111, plus 0011011 if XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - Anything else: NONE.
- **Immediates, per RISC-V base spec.** Sign bit is always instr[31], extended to XLEN.
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- **Illegal** when any of these holds:
  - opcode[1:0]≠2'b11;
  - fmt=NONE;
  - R-type with funct7 ∉ {0000000, 0100000, 0000001}.
  - Illegal entries still flow with all fields populated. They are never dropped.
- **SKID=1 state machine.** States are EMPTY, ONE (main valid) and TWO (main+skid valid). `in_ready` = (state≠TWO), registered.
  - EMPTY: accept → ONE.
  - ONE: accept and no present → TWO (new entry goes to skid). Present and no accept → EMPTY. Both → ONE (new entry goes to main).
  - TWO: present → ONE. Skid promotes to main; no accept, since `in_ready`=0.
- **SKID=0.** `in_ready` = !out_valid || out_ready. A single register holds the entry.
- **Ordering.** Strict FIFO order; no entry lost or duplicated.
- **Flush.** Next state is EMPTY and `out_valid` is 0 next cycle.
  - Flush beats a same-cycle accept; the input is dropped.
  - A same-cycle present still counts as consumed downstream.
- **Stability.** Output fields hold steady while `out_valid && !out_ready`.

## Timing
- Latency: accept in cycle N gives `out_valid`=1 in cycle N+1.
- Throughput is 1 instruction/cycle when `out_ready`=1, in both SKID modes.
- Reset values:
  - state EMPTY;
  - `out_valid`=0;
  - `in_ready`=1 (SKID=1);
  - all field outputs, `out_imm` and `out_pc` = 0;
  - `out_fmt`=NONE;
  - `out_illegal`=0.
- `rst_n` asserted mid-stream clears every entry immediately (asynchronously). The first accept is possible on the first rising edge after deassertion.
- `out_ready` deasserted with state ONE and `in_valid`=1: one more input is accepted into skid, then `in_ready`=0 from the following cycle.

## Structure
- Shared package `decode_pkg`:
  - opcode constants;
  - `fmt_t` encoding (R..J, NONE);
  - a packed `decoded_t` struct (fields, imm, fmt, illegal, pc).
- Sub-module `instr_field_decode` is purely combinational: `in_instr` → `decoded_t` minus pc. It is parametrised by XLEN.
- Top: the SKID/non-SKID register and control, selected by generate on `SKID`.

## Test plan
- addi x1,x2,-1 (0xFFF10093) → rd=1, rs1=2, funct3=0, fmt=I, imm=0xFFFFFFFF (XLEN=32), illegal=0, one cycle after accept.
- sw x5,8(x6) (0x00532423) then lui x3,0x12345 (0x123451B7), back-to-back:
  - first gives fmt=S, rs1=6, rs2=5, imm=8;
  - second gives fmt=U, rd=3, imm=0x12345000;
  - outputs on consecutive cycles.
- Three instructions with `out_ready`=0 for 3 cycles (SKID=1):
  - two are accepted and `in_ready` falls;
  - after `out_ready`=1 all three emerge in order with no loss.
- 0x00000000 and R-type funct7=0x7F → `out_illegal`=1, with the entries still presented.
- Flush in state TWO with `in_valid`=1 → `out_valid`=0 and `in_ready`=1 next cycle; the flushed input is never presented.
- `rst_n` pulsed low mid-stream → outputs reach their reset values immediately; after release, first accept gives `out_valid` one cycle later.
